// File: rtl/moore_seq_detector.sv
// moore_seq_detector: parametrised Moore serial-pattern detector.
// A PAT_W-bit history shift register is compared against a run-time
// loadable pattern; the registered match flag drives y. A saturating
// counter with a sticky saturation flag tallies matches.
module moore_seq_detector #(
    parameter int unsigned          PAT_W   = 3,
    parameter logic [PAT_W-1:0]     PATTERN = 3'b101,
    parameter bit                   OVERLAP = 1'b1,
    parameter int unsigned          CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             x,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             cnt_clr,
    output logic             y,
    output logic [CNT_W-1:0] match_count,
    output logic             count_sat
);

    localparam int unsigned      FILL_W   = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);

    // What this edge does to the detector state (reset is handled in the register).
    typedef enum logic [1:0] {
        ACT_HOLD   = 2'd0,
        ACT_LOAD   = 2'd1,
        ACT_SAMPLE = 2'd2
    } act_e;

    act_e              act;

    logic [PAT_W-1:0]  pattern_q, pattern_d;
    logic [PAT_W-1:0]  hist_q,    hist_d;
    logic [FILL_W-1:0] fill_q,    fill_d;
    logic              match_q,   match_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic              sat_q,     sat_d;

    logic [PAT_W-1:0]  hist_shift;
    logic [FILL_W-1:0] fill_n;
    logic [CNT_W-1:0]  cnt_inc;
    logic              hit;

    // New bit enters at the LSB; a 1-bit pattern has no older bits to keep.
    if (PAT_W == 1) begin : g_hist_w1
        assign hist_shift = x;
    end else begin : g_hist_wn
        assign hist_shift = {hist_q[PAT_W-2:0], x};
    end

    // Priority decode of the per-edge action: pat_load beats en.
    always_comb begin
        act = ACT_HOLD;
        if (pat_load) begin
            act = ACT_LOAD;
        end else if (en) begin
            act = ACT_SAMPLE;
        end
    end

    // Match detection on the shifted history, gated by a full window.
    always_comb begin
        fill_n = (fill_q == FILL_MAX) ? FILL_MAX : fill_q + 1'b1;
        hit    = (act == ACT_SAMPLE) && (fill_n == FILL_MAX) && (hist_shift == pattern_q);
    end

    // Next-state logic for pattern, history, fill and match flag.
    always_comb begin
        pattern_d = pattern_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        match_d   = match_q;
        unique case (act)
            ACT_LOAD: begin
                // History is kept but declared empty, so no match spans a load.
                pattern_d = pat_in;
                fill_d    = '0;
                match_d   = 1'b0;
            end
            ACT_SAMPLE: begin
                hist_d  = hist_shift;
                match_d = hit;
                if (hit && !OVERLAP) begin
                    fill_d = '0;
                end else begin
                    fill_d = fill_n;
                end
            end
            default: ;
        endcase
    end

    // Next-state logic for the saturating match counter and sticky flag.
    always_comb begin
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        cnt_inc = cnt_q + 1'b1;
        if (cnt_clr) begin
            // A clear coinciding with a hit counts that hit as the first one.
            if (hit) begin
                cnt_d = CNT_W'(1);
                sat_d = (CNT_W == 1);
            end else begin
                cnt_d = '0;
                sat_d = 1'b0;
            end
        end else if (hit && (cnt_q != '1)) begin
            cnt_d = cnt_inc;
            sat_d = sat_q | (&cnt_inc);
        end
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pattern_q <= PATTERN;
            hist_q    <= '0;
            fill_q    <= '0;
            match_q   <= 1'b0;
            cnt_q     <= '0;
            sat_q     <= 1'b0;
        end else begin
            pattern_q <= pattern_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            match_q   <= match_d;
            cnt_q     <= cnt_d;
            sat_q     <= sat_d;
        end
    end

    // Moore outputs decoded from registered state only.
    always_comb begin
        y           = match_q;
        match_count = cnt_q;
        count_sat   = sat_q;
    end

endmodule

// File: tb/tb_moore_seq_detector.sv
// Scoreboard bench for moore_seq_detector: three instances (default,
// non-overlapping, 2-bit counter) share stimulus; expected outputs are
// queued after each edge and checked by an independent monitor.
module tb_moore_seq_detector;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       x = 1'b0;
    logic       pat_load = 1'b0;
    logic [2:0] pat_in = 3'b000;
    logic       cnt_clr = 1'b0;

    logic       ya, yb, yc;
    logic [7:0] cnta, cntb;
    logic [1:0] cntc;
    logic       sata, satb, satc;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int         id;
        logic       y;
        logic [7:0] cnt;
        logic       sat;
        string      tag;
    } exp_t;

    exp_t sbq[$];

    always #5 clk = ~clk;

    moore_seq_detector #(.PAT_W(3), .PATTERN(3'b101), .OVERLAP(1'b1), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .en(en), .x(x), .pat_load(pat_load), .pat_in(pat_in),
        .cnt_clr(cnt_clr), .y(ya), .match_count(cnta), .count_sat(sata)
    );

    moore_seq_detector #(.PAT_W(3), .PATTERN(3'b101), .OVERLAP(1'b0), .CNT_W(8)) dut_b (
        .clk(clk), .reset(reset), .en(en), .x(x), .pat_load(pat_load), .pat_in(pat_in),
        .cnt_clr(cnt_clr), .y(yb), .match_count(cntb), .count_sat(satb)
    );

    moore_seq_detector #(.PAT_W(3), .PATTERN(3'b101), .OVERLAP(1'b1), .CNT_W(2)) dut_c (
        .clk(clk), .reset(reset), .en(en), .x(x), .pat_load(pat_load), .pat_in(pat_in),
        .cnt_clr(cnt_clr), .y(yc), .match_count(cntc), .count_sat(satc)
    );

    task automatic drive(input logic r, input logic e, input logic xi, input logic ld,
                         input logic [2:0] p, input logic clr);
        @(negedge clk);
        reset    = r;
        en       = e;
        x        = xi;
        pat_load = ld;
        pat_in   = p;
        cnt_clr  = clr;
        @(posedge clk);
    endtask

    task automatic bit_in(input logic xi);
        drive(1'b0, 1'b1, xi, 1'b0, 3'b000, 1'b0);
    endtask

    task automatic ex(input int id, input logic ye, input logic [7:0] ce, input logic se,
                      input string tag);
        exp_t e;
        e.id  = id;
        e.y   = ye;
        e.cnt = ce;
        e.sat = se;
        e.tag = tag;
        sbq.push_back(e);
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
        ex(0, 1'b0, 8'd0, 1'b0, "rst_a");
        ex(1, 1'b0, 8'd0, 1'b0, "rst_b");
        ex(2, 1'b0, 8'd0, 1'b0, "rst_c");
    endtask

    // Monitor: registered outputs are stable at the falling edge.
    always @(negedge clk) begin : monitor
        exp_t       e;
        logic       ay;
        logic [7:0] ac;
        logic       as;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            case (e.id)
                0:       begin ay = ya; ac = cnta;          as = sata; end
                1:       begin ay = yb; ac = cntb;          as = satb; end
                default: begin ay = yc; ac = {6'd0, cntc};  as = satc; end
            endcase
            n_chk = n_chk + 1;
            if (ay !== e.y) begin
                n_fail = n_fail + 1;
                $display("FAIL %s.y dut=%0d got=%b expected=%b @%0t", e.tag, e.id, ay, e.y, $time);
            end
            n_chk = n_chk + 1;
            if (ac !== e.cnt) begin
                n_fail = n_fail + 1;
                $display("FAIL %s.count dut=%0d got=%0d expected=%0d @%0t", e.tag, e.id, ac, e.cnt, $time);
            end
            n_chk = n_chk + 1;
            if (as !== e.sat) begin
                n_fail = n_fail + 1;
                $display("FAIL %s.sat dut=%0d got=%b expected=%b @%0t", e.tag, e.id, as, e.sat, $time);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : stim
        do_reset();

        // T1 (overlap) and T2 (non-overlap) on the same stream 1,0,1,0,1
        bit_in(1'b1); ex(0, 0, 0, 0, "t1_b1"); ex(1, 0, 0, 0, "t2_b1");
        bit_in(1'b0); ex(0, 0, 0, 0, "t1_b2"); ex(1, 0, 0, 0, "t2_b2");
        bit_in(1'b1); ex(0, 1, 1, 0, "t1_b3"); ex(1, 1, 1, 0, "t2_b3");
        bit_in(1'b0); ex(0, 0, 1, 0, "t1_b4"); ex(1, 0, 1, 0, "t2_b4");
        bit_in(1'b1); ex(0, 1, 2, 0, "t1_b5"); ex(1, 0, 1, 0, "t2_b5");

        // T3: sample-enable gaps; y holds while en=0
        do_reset();
        bit_in(1'b1);                                   ex(0, 0, 0, 0, "t3_e1");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);    ex(0, 0, 0, 0, "t3_gap");
        bit_in(1'b0);                                   ex(0, 0, 0, 0, "t3_e2");
        bit_in(1'b1);                                   ex(0, 1, 1, 0, "t3_hit");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);    ex(0, 1, 1, 0, "t3_hold");
        bit_in(1'b0);                                   ex(0, 0, 1, 0, "t3_after");

        // T4: pattern load mid-stream (x/en ignored on the load edge)
        do_reset();
        bit_in(1'b1);                                   ex(0, 0, 0, 0, "t4_p1");
        bit_in(1'b0);                                   ex(0, 0, 0, 0, "t4_p2");
        drive(1'b0, 1'b1, 1'b1, 1'b1, 3'b110, 1'b0);    ex(0, 0, 0, 0, "t4_load");
        bit_in(1'b1);                                   ex(0, 0, 0, 0, "t4_b1");
        bit_in(1'b1);                                   ex(0, 0, 0, 0, "t4_b2");
        bit_in(1'b0);                                   ex(0, 1, 1, 0, "t4_hit");

        // T5: 2-bit counter saturation, then clear on a hit, then clear alone
        do_reset();
        bit_in(1'b1); ex(2, 0, 0, 0, "t5_b1");
        bit_in(1'b0); ex(2, 0, 0, 0, "t5_b2");
        bit_in(1'b1); ex(2, 1, 1, 0, "t5_b3");
        bit_in(1'b0); ex(2, 0, 1, 0, "t5_b4");
        bit_in(1'b1); ex(2, 1, 2, 0, "t5_b5");
        bit_in(1'b0); ex(2, 0, 2, 0, "t5_b6");
        bit_in(1'b1); ex(2, 1, 3, 1, "t5_b7");
        bit_in(1'b0); ex(2, 0, 3, 1, "t5_b8");
        bit_in(1'b1); ex(2, 1, 3, 1, "t5_b9"); ex(0, 1, 4, 0, "t5_a9");
        bit_in(1'b0); ex(2, 0, 3, 1, "t5_b10");
        drive(1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 1'b1);
        ex(2, 1, 1, 0, "t5_clrhit"); ex(0, 1, 1, 0, "t5_a_clrhit");
        drive(1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1);
        ex(2, 0, 0, 0, "t5_clr");

        // T6: reset mid-stream (also overriding a pat_load) discards history
        do_reset();
        bit_in(1'b1);                                   ex(0, 0, 0, 0, "t6_p1");
        bit_in(1'b0);                                   ex(0, 0, 0, 0, "t6_p2");
        drive(1'b1, 1'b1, 1'b1, 1'b1, 3'b000, 1'b0);    ex(0, 0, 0, 0, "t6_rst");
        bit_in(1'b1);                                   ex(0, 0, 0, 0, "t6_b1");
        bit_in(1'b0);                                   ex(0, 0, 0, 0, "t6_b2");
        bit_in(1'b1);                                   ex(0, 1, 1, 0, "t6_hit");

        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
        @(negedge clk);
        @(negedge clk);
        n_chk = n_chk + 1;
        if (sbq.size() != 0) begin
            n_fail = n_fail + 1;
            $display("FAIL drain: %0d expectations left, expected 0", sbq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
